regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised three-port register file with a built-in scoreboard for the pipelined processor datapath. It replaces the fixed 32x32 register file and adds the following:
- configurable width and depth;
- optional hardwired-zero register;
- optional write-to-read bypass;
- synchronous clear;
- per-register pending bits that track destinations of in-flight multicycle operations, so decode can detect RAW hazards.

It sits between decode (reads, issue) and writeback (writes).

## Interface
Parameters:
- WIDTH, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/issues; 0 = register 0 is ordinary
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads return stored value only

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers, pending bits and count
- we3  input  1  writeback enable
- wa3  input  ADDR_W  writeback address
- wd3  input  WIDTH  writeback data
- ra1, ra2  input  ADDR_W  read addresses
- rd1, rd2  output  WIDTH  read data (combinational)
- iss_en  input  1  issue: mark destination pending
- iss_wa  input  ADDR_W  issued destination address
- pend1, pend2  output  1  source ra1/ra2 not yet valid (combinational)
- npend  output  ADDR_W+1  number of pending bits currently set

## Operation
- Storage: DEPTH x WIDTH registers `rf` and DEPTH pending bits `pend`.
- Zero register ("zero-reg") behaviour applies when ZERO_REG=1 and an address is 0:
  - reads of that address return 0;
  - writes to it are dropped;
  - issues to it are dropped;
  - its pending bit is constant 0.
- Write: on a clk edge with we3=1 and wa3 not zero-reg, `rf[wa3] <= wd3`.
- Read, port n = 1/2:
  - if ra_n is zero-reg, rd_n = 0;
  - else if BYPASS=1, we3=1 and wa3==ra_n, rd_n = wd3;
  - else rd_n = rf[ra_n].
- Pending set: on a clk edge with iss_en=1 and iss_wa not zero-reg, `pend[iss_wa] <= 1`.
- Pending clear: on a clk edge with we3=1 and wa3 not zero-reg, `pend[wa3] <= 0`. This happens even if the bit was already 0, which covers single-cycle ops.
- Simultaneous issue and writeback to the same address: the issue wins and the bit stays/becomes 1, because the new producer supersedes.
- Issue to an already-pending register: the bit stays 1 and npend is unchanged. Stalling on WAW hazards is decode's responsibility.
- Source-pending outputs:
  - pend_n = pend[ra_n] AND NOT (BYPASS=1 AND we3=1 AND wa3==ra_n);
  - a zero-reg source is never pending;
  - with BYPASS=0, pend_n = pend[ra_n].
- npend update per edge: npend_next = npend + (set of a 0 bit) - (clear of a 1 bit).
  - A set and a clear of different bits in one cycle gives a net 0.
  - npend always equals the popcount of `pend`, with range 0..DEPTH (or DEPTH-1 when ZERO_REG=1).
- Reset has priority over we3 and iss_en in the same cycle. It clears:
  - every `rf` entry to 0;
  - every `pend` bit to 0;
  - npend to 0.

  In-flight operations are discarded: their later writebacks write data normally but never underflow npend, because clears of 0 bits do not decrement.

## Timing
- Read latency is 0 cycles; rd_n and pend_n are combinational from addresses and state.
- Write-to-read latency:
  - 0 cycles with BYPASS=1;
  - 1 cycle (visible after the edge) with BYPASS=0.
- Issue-to-pend latency is 1 cycle: pend_n rises in the cycle after the iss_en edge. Decode must account for a same-cycle issue itself.
- Reset values in the cycle after reset is asserted: rd1=rd2=0 (for any address with we3=0), pend1=pend2=0, npend=0.
- No handshake back-pressure: every we3/iss_en is accepted on the edge where it is sampled.

## Test plan
- Reset, then read all addresses with we3=0 -> every rd1/rd2 = 0, pend1=pend2=0, npend=0.
- Write 0xDEADBEEF to r5 with ra1=5 in the same cycle, BYPASS=1 -> rd1=0xDEADBEEF in that cycle. With BYPASS=0 -> rd1=0 in that cycle and 0xDEADBEEF in the next.
- Zero register:
  - ZERO_REG=1, we3=1, wa3=0, wd3=0x1234, plus iss_en to r0 -> rd1(ra1=0)=0 always, npend stays 0;
  - ZERO_REG=0, same stimulus -> r0 reads 0x1234.
- Issue r7, r9, r7 on consecutive cycles -> npend = 1, 2, 2; pend1 (ra1=7) = 1.
  - Then writeback r7 -> pend1=0 in the writeback cycle (BYPASS=1) and npend=1 next cycle.
- Same cycle: iss_en to r3, we3 to r3 with data 0x55 -> rf[3]=0x55, pend[3]=1, npend incremented by 1.
- Issue r4 and r6, assert reset for one cycle, then writeback r4 -> npend = 0 after reset and still 0 after the writeback; rf[4] holds the written data.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised three-port register file with per-register pending bits
// that let decode detect RAW hazards on in-flight multicycle destinations.
module regfile_sb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_wa,
  output logic              pend1,
  output logic              pend2,
  output logic [ADDR_W:0]   npend
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] npend_q, npend_d;
  logic             wr_ok, iss_ok, inc, dec;
  logic             hit1, hit2, zero1, zero2;

  // Pending-bit and counter next state; an issue overrides a same-address writeback.
  always_comb begin
    wr_ok  = we3 && !(ZERO_REG && (wa3 == '0));
    iss_ok = iss_en && !(ZERO_REG && (iss_wa == '0));
    pend_d = pend_q;
    if (wr_ok) begin
      pend_d[wa3] = 1'b0;
    end
    if (iss_ok) begin
      pend_d[iss_wa] = 1'b1;
    end
    inc     = iss_ok && !pend_q[iss_wa];
    dec     = wr_ok && pend_q[wa3] && !(iss_ok && (iss_wa == wa3));
    npend_d = npend_q + CNT_W'(inc) - CNT_W'(dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
      pend_q  <= '0;
      npend_q <= '0;
    end else begin
      if (wr_ok) begin
        rf_q[wa3] <= wd3;
      end
      pend_q  <= pend_d;
      npend_q <= npend_d;
    end
  end

  // Read ports: zero register first, then same-cycle writeback forwarding.
  always_comb begin
    hit1  = BYPASS && we3 && (wa3 == ra1);
    zero1 = ZERO_REG && (ra1 == '0);
    rd1   = rf_q[ra1];
    if (hit1) begin
      rd1 = wd3;
    end
    if (zero1) begin
      rd1 = '0;
    end
    pend1 = pend_q[ra1] && !hit1 && !zero1;
  end

  always_comb begin
    hit2  = BYPASS && we3 && (wa3 == ra2);
    zero2 = ZERO_REG && (ra2 == '0);
    rd2   = rf_q[ra2];
    if (hit2) begin
      rd2 = wd3;
    end
    if (zero2) begin
      rd2 = '0;
    end
    pend2 = pend_q[ra2] && !hit2 && !zero2;
  end

  assign npend = npend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (zero-reg+bypass, plain)
// share stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_regfile_sb;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        p1;
    logic        p2;
    logic [5:0]  np;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [4:0]  ra1, ra2;
  logic        iss_en;
  logic [4:0]  iss_wa;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        pend1_a, pend2_a, pend1_b, pend2_b;
  logic [5:0]  npend_a, npend_b;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference state per instance: index 0 = zero-reg+bypass, 1 = neither
  logic [31:0] m_rf   [2][32];
  bit          m_pend [2][32];
  bit          cfg_zr [2] = '{1'b1, 1'b0};
  bit          cfg_bp [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .iss_en(iss_en), .iss_wa(iss_wa), .pend1(pend1_a), .pend2(pend2_a),
    .npend(npend_a)
  );

  regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .iss_en(iss_en), .iss_wa(iss_wa), .pend1(pend1_b), .pend2(pend2_b),
    .npend(npend_b)
  );

  function automatic logic [31:0] m_data(input int k, input logic [4:0] ra);
    if (cfg_zr[k] && ra == 5'd0) return 32'd0;
    if (cfg_bp[k] && we3 && wa3 == ra) return wd3;
    return m_rf[k][ra];
  endfunction

  function automatic logic m_src_pend(input int k, input logic [4:0] ra);
    if (cfg_zr[k] && ra == 5'd0) return 1'b0;
    if (cfg_bp[k] && we3 && wa3 == ra) return 1'b0;
    return m_pend[k][ra];
  endfunction

  function automatic exp_t model_read(input int k);
    exp_t e;
    int   cnt = 0;
    for (int i = 0; i < 32; i++) cnt += int'(m_pend[k][i]);
    e.rd1 = m_data(k, ra1);
    e.rd2 = m_data(k, ra2);
    e.p1  = m_src_pend(k, ra1);
    e.p2  = m_src_pend(k, ra2);
    e.np  = 6'(cnt);
    return e;
  endfunction

  task automatic model_edge(input int k);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_rf[k][i]   = 32'd0;
        m_pend[k][i] = 1'b0;
      end
    end else begin
      if (we3 && !(cfg_zr[k] && wa3 == 5'd0)) begin
        m_rf[k][wa3]   = wd3;
        m_pend[k][wa3] = 1'b0;
      end
      if (iss_en && !(cfg_zr[k] && iss_wa == 5'd0)) m_pend[k][iss_wa] = 1'b1;
    end
  endtask

  // One clock cycle of stimulus; expected outputs are queued before the edge is modelled.
  task automatic cyc(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input bit ie, input logic [4:0] iw, input bit chk = 1'b1);
    @(posedge clk);
    #1;
    cyc_n++;
    reset = r; we3 = we; wa3 = wa; wd3 = wd;
    ra1 = a1; ra2 = a2; iss_en = ie; iss_wa = iw;
    if (chk) begin
      q_a.push_back(model_read(0));
      q_b.push_back(model_read(1));
    end
    model_edge(0);
    model_edge(1);
  endtask

  task automatic check(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", nm, k, cyc_n, got, exp);
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("rd1", 0, rd1_a, e.rd1);
        check("rd2", 0, rd2_a, e.rd2);
        check("pend1", 0, 32'(pend1_a), 32'(e.p1));
        check("pend2", 0, 32'(pend2_a), 32'(e.p2));
        check("npend", 0, 32'(npend_a), 32'(e.np));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("rd1", 1, rd1_b, e.rd1);
        check("rd2", 1, rd2_b, e.rd2);
        check("pend1", 1, 32'(pend1_b), 32'(e.p1));
        check("pend2", 1, 32'(pend2_b), 32'(e.p2));
        check("npend", 1, 32'(npend_b), 32'(e.np));
      end
    end
  end

  initial begin
    reset = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0;
    ra1 = '0; ra2 = '0; iss_en = 1'b0; iss_wa = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state over every address
    for (int a = 0; a < 32; a++) cyc(0, 0, 0, 0, 5'(a), 5'(31 - a), 0, 0);

    // Write-to-read forwarding vs. stored value
    cyc(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 5, 5, 0, 0);

    // Register 0 write plus issue
    cyc(0, 1, 0, 32'h1234, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 5, 0, 0);

    // Issue r7, r9, r7 then writeback r7
    cyc(0, 0, 0, 0, 7, 9, 1, 7);
    cyc(0, 0, 0, 0, 7, 9, 1, 9);
    cyc(0, 0, 0, 0, 7, 9, 1, 7);
    cyc(0, 1, 7, 32'hA5A5_0007, 7, 9, 0, 0);
    cyc(0, 0, 0, 0, 7, 9, 0, 0);

    // Same-cycle issue and writeback to r3
    cyc(0, 1, 3, 32'h55, 3, 0, 1, 3);
    cyc(0, 0, 0, 0, 3, 3, 0, 0);

    // Reset discards in-flight ops; later writeback must not underflow
    cyc(0, 0, 0, 0, 4, 6, 1, 4);
    cyc(0, 0, 0, 0, 4, 6, 1, 6);
    cyc(1, 0, 0, 0, 4, 6, 0, 0);
    cyc(0, 1, 4, 32'hCAFE_0004, 4, 6, 0, 0);
    cyc(0, 0, 0, 0, 4, 6, 0, 0);

    // Randomized traffic concentrated on a few registers to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 3) != 0);
      cyc(($urandom_range(0, 99) == 0),
          1'($urandom_range(0, 1)),
          narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
          $urandom,
          narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
          narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
          1'($urandom_range(0, 1)),
          narrow ? 5'($urandom_range(0, 7)) : 5'($urandom));
    end

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    n_chk++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d/%0d pending exp=0", q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
